// File: rtl/nios_debug_ocimem_if.sv
// nios_debug_ocimem_if: JTAG debug strobes/status and CPU Avalon-MM port of the debug RAM
interface nios_debug_ocimem_if #(parameter int ADDR_W = 8);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic              jtag_busy;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic              avs_waitrequest;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  MonDReg, monitor_ready, monitor_error, jtag_busy,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output MonDReg, monitor_ready, monitor_error, jtag_busy,
        output avs_readdata, avs_readdatavalid, avs_waitrequest
    );
endinterface

// File: rtl/nios_debug_ocimem.sv
// nios_debug_ocimem: debug RAM shared by the JTAG monitor (priority) and a CPU Avalon-MM slave
module nios_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input logic                 clk,
    input logic                 reset,
    nios_debug_ocimem_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] JRD  = 2'd1;
    localparam logic [1:0] JCAP = 2'd2;
    localparam logic [1:0] JWR  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_mon_a;
    logic [31:0]       r_mon_d, r_wdata, r_q, r_hold;
    logic              r_ready, r_err, r_rdv;
    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

    logic              w_a, w_na, w_b, w_idle, w_any, w_wait, w_cpu_wr, w_cpu_rd;
    logic              w_jtag, w_we, w_re, w_drop, w_clr, w_unused;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wd;
    logic [3:0]        w_be;

    assign w_a      = bus.take_action_ocimem_a;
    assign w_na     = bus.take_no_action_ocimem_a;
    assign w_b      = bus.take_action_ocimem_b;
    assign w_idle   = r_state == IDLE;
    assign w_any    = w_a | w_na | w_b;
    assign w_wait   = (bus.avs_read | bus.avs_write) & (!w_idle | w_any);
    assign w_cpu_wr = bus.avs_write & !w_wait;
    assign w_cpu_rd = bus.avs_read & !bus.avs_write & !w_wait;
    assign w_jtag   = r_state == JWR || r_state == JRD;
    assign w_addr   = w_jtag ? r_mon_a : bus.avs_address;
    assign w_we     = r_state == JWR || w_cpu_wr;
    assign w_re     = r_state == JRD || w_cpu_rd;
    assign w_wd     = r_state == JWR ? r_wdata : bus.avs_writedata;
    assign w_be     = r_state == JWR ? 4'hf : bus.avs_byteenable;
    // a strobe is lost if it collides with a higher-priority one or arrives while busy
    assign w_drop   = w_idle ? (w_b & (w_a | w_na)) | (w_a & w_na) : w_any;
    assign w_clr    = w_idle & !w_b & w_a & bus.jdo[37];
    assign w_unused = ^{bus.jdo[36], bus.jdo[2:0]};

    assign bus.MonDReg           = r_mon_d;
    assign bus.monitor_ready     = r_ready;
    assign bus.monitor_error     = r_err;
    assign bus.jtag_busy         = !w_idle;
    assign bus.avs_waitrequest   = w_wait;
    assign bus.avs_readdatavalid = r_rdv;
    assign bus.avs_readdata      = r_rdv ? r_q : r_hold;

    // byte-lane RAM write; contents survive reset, writes are blocked while it is held
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (!reset && w_we && w_be[i]) r_mem[w_addr][8*i +: 8] <= w_wd[8*i +: 8];
    end

    // synchronous RAM read port shared by JTAG and CPU reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_q <= '0;
        else if (w_re) r_q <= r_mem[w_addr];
    end

    // CPU read data is valid the cycle after acceptance and held afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdv  <= 1'b0;
            r_hold <= '0;
        end else begin
            r_rdv  <= w_cpu_rd;
            r_hold <= r_rdv ? r_q : r_hold;
        end
    end

    // JTAG monitor state machine, address/data registers and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_mon_a <= '0;
            r_mon_d <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_drop ? 1'b1 : w_clr ? 1'b0 : r_err;
            case (r_state)
                IDLE: begin
                    if (w_b) begin
                        r_wdata <= bus.jdo[34:3];
                        r_state <= JWR;
                    end else if (w_a) begin
                        r_mon_a <= bus.jdo[ADDR_W+16:17];
                        r_ready <= 1'b0;
                        r_state <= bus.jdo[35] ? JRD : IDLE;
                    end else if (w_na) begin
                        r_ready <= 1'b0;
                        r_state <= JRD;
                    end
                end
                JRD: r_state <= JCAP;
                JCAP: begin
                    r_mon_d <= r_q;
                    r_mon_a <= r_mon_a + ADDR_W'(1);
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_mon_a <= r_mon_a + ADDR_W'(1);
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
